// File: rtl/dpll_pkg.sv
// Shared DPLL front-end definitions: default conditioner depths and a
// constant clog2 for sizing counters at elaboration time.
package dpll_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FILT_CNT_DEF    = 4;

    // Smallest r with 2**r >= v; used only in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sig_filter_ch.sv
// One conditioner channel: N-flop synchroniser, stable-count glitch filter,
// registered level with rise/fall strobes and a sticky glitch flag.
module sig_filter_ch
    import dpll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILT_CNT    = FILT_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sig_in,
    input  logic clr_glitch,
    output logic sig_out,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int unsigned      CNT_W    = clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   out_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   glitch_d;

    assign s = sync_q[SYNC_STAGES-1];

    // A level is accepted after FILT_CNT consecutive differing samples; an
    // early return to the current level is reported as a glitch.
    always_comb begin
        cnt_d    = cnt_q;
        out_d    = sig_out;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch;
        if (clr_glitch) begin
            glitch_d = 1'b0;
        end
        if (en) begin
            if (s == sig_out) begin
                cnt_d = '0;
                if (cnt_q != '0) begin
                    glitch_d = 1'b1;
                end
            end else if (cnt_q == CNT_LAST) begin
                out_d  = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser shifts regardless of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            sig_out <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            glitch  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            cnt_q   <= cnt_d;
            sig_out <= out_d;
            rise    <= rise_d;
            fall    <= fall_d;
            glitch  <= glitch_d;
        end
    end

endmodule

// File: rtl/sig_sync_filter.sv
// WIDTH-channel input conditioner for the DPLL front end; channels are
// fully independent copies of sig_filter_ch.
module sig_sync_filter
    import dpll_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILT_CNT    = FILT_CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sigIn,
    input  logic [WIDTH-1:0] clr_glitch,
    output logic [WIDTH-1:0] sigOut,
    output logic [WIDTH-1:0] sigOut_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] glitch
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
        sig_filter_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CNT   (FILT_CNT)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .sig_in    (sigIn[i]),
            .clr_glitch(clr_glitch[i]),
            .sig_out   (sigOut[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .glitch    (glitch[i])
        );
    end

    // Complement is taken straight from the registered level.
    assign sigOut_n = ~sigOut;

endmodule

// File: tb/tb_sig_sync_filter.sv
// Bench for sig_sync_filter: default, deep (3 sync / 5 filter) and
// pass-through (FILT_CNT=1) instances driven from one scenario sequence.
module tb_sig_sync_filter;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] gl;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    exp_t sb[$];

    logic       a_reset, a_en;
    logic [1:0] a_in, a_clr, a_out, a_out_n, a_rise, a_fall, a_gl;
    logic       b_reset, b_en;
    logic [3:0] b_in, b_clr, b_out, b_out_n, b_rise, b_fall, b_gl;
    logic       c_reset, c_en;
    logic [1:0] c_in, c_clr, c_out, c_out_n, c_rise, c_fall, c_gl;

    sig_sync_filter #(.WIDTH(2)) u_a (
        .clk(clk), .reset(a_reset), .en(a_en), .sigIn(a_in), .clr_glitch(a_clr),
        .sigOut(a_out), .sigOut_n(a_out_n), .rise(a_rise), .fall(a_fall), .glitch(a_gl)
    );

    sig_sync_filter #(.WIDTH(4), .SYNC_STAGES(3), .FILT_CNT(5)) u_b (
        .clk(clk), .reset(b_reset), .en(b_en), .sigIn(b_in), .clr_glitch(b_clr),
        .sigOut(b_out), .sigOut_n(b_out_n), .rise(b_rise), .fall(b_fall), .glitch(b_gl)
    );

    sig_sync_filter #(.WIDTH(2), .FILT_CNT(1)) u_c (
        .clk(clk), .reset(c_reset), .en(c_en), .sigIn(c_in), .clr_glitch(c_clr),
        .sigOut(c_out), .sigOut_n(c_out_n), .rise(c_rise), .fall(c_fall), .glitch(c_gl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t obs_a();
        return exp_t'({2'b00, a_out, 2'b00, a_rise, 2'b00, a_fall, 2'b00, a_gl});
    endfunction

    function automatic exp_t obs_b();
        return exp_t'({b_out, b_rise, b_fall, b_gl});
    endfunction

    task automatic reset_a();
        a_reset = 1'b1;
        a_in    = 2'b00;
        a_clr   = 2'b00;
        a_en    = 1'b1;
        repeat (2) tick();
        a_reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        a_reset = 1'b1;
        a_in    = 2'b11;
        a_en    = 1'b1;
        a_clr   = 2'b11;
        repeat (3) tick();
        n_chk++;
        if ({a_out, a_out_n, a_rise, a_fall, a_gl} !== 10'b00_11_00_00_00) begin
            $display("FAIL reset_state: got %b want %b",
                     {a_out, a_out_n, a_rise, a_fall, a_gl}, 10'b00_11_00_00_00);
        end else begin
            n_pass++;
        end
        a_reset = 1'b0;
        a_clr   = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            e.out  = (k >= 6) ? 4'h3 : 4'h0;
            e.rise = (k == 6) ? 4'h3 : 4'h0;
            e.fall = 4'h0;
            e.gl   = 4'h0;
            sb.push_back(e);
        end
        for (int k = 1; sb.size() > 0; k++) begin
            tick();
            e = sb.pop_front();
            n_chk++;
            if (obs_a() !== e || a_out_n !== ~e.out[1:0]) begin
                $display("FAIL reset_release edge %0d: got %h/n=%b want %h", k, obs_a(), a_out_n, e);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        reset_a();
        for (int k = 1; k <= 13; k++) begin
            a_in   = (k <= 3) ? 2'b01 : 2'b00;
            a_clr  = (k == 11) ? 2'b01 : 2'b00;
            e.out  = 4'h0;
            e.rise = 4'h0;
            e.fall = 4'h0;
            e.gl   = (k >= 6 && k <= 10) ? 4'h1 : 4'h0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_chk++;
            if (obs_a() !== e) begin
                $display("FAIL glitch edge %0d: got %h want %h", k, obs_a(), e);
            end else begin
                n_pass++;
            end
        end
        a_clr = 2'b00;
    endtask

    task automatic test_enable();
        exp_t e;
        reset_a();
        a_en = 1'b0;
        a_in = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            if (k == 11) a_en = 1'b1;
            e.out  = (k >= 14) ? 4'h3 : 4'h0;
            e.rise = (k == 14) ? 4'h3 : 4'h0;
            e.fall = 4'h0;
            e.gl   = 4'h0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_chk++;
            if (obs_a() !== e) begin
                $display("FAIL enable edge %0d: got %h want %h", k, obs_a(), e);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_set_clear();
        exp_t e;
        reset_a();
        // Glitch on ch1 detected at edge 6 while clear is also requested.
        for (int k = 1; k <= 7; k++) begin
            a_in   = (k <= 3) ? 2'b10 : 2'b00;
            a_clr  = (k == 6) ? 2'b10 : 2'b00;
            e.out  = 4'h0;
            e.rise = 4'h0;
            e.fall = 4'h0;
            e.gl   = (k >= 6) ? 4'h2 : 4'h0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_chk++;
            if (obs_a() !== e) begin
                $display("FAIL set_clear edge %0d: got %h want %h", k, obs_a(), e);
            end else begin
                n_pass++;
            end
        end
        // Counter reaches 2 after edge 4, then reset lands on edge 5.
        a_in = 2'b10;
        repeat (4) tick();
        a_reset = 1'b1;
        tick();
        n_chk++;
        if ({a_out, a_out_n, a_rise, a_fall, a_gl} !== 10'b00_11_00_00_00) begin
            $display("FAIL mid_reset: got %b want %b",
                     {a_out, a_out_n, a_rise, a_fall, a_gl}, 10'b00_11_00_00_00);
        end else begin
            n_pass++;
        end
        a_reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            e.out  = (k >= 6) ? 4'h2 : 4'h0;
            e.rise = (k == 6) ? 4'h2 : 4'h0;
            e.fall = 4'h0;
            e.gl   = 4'h0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_chk++;
            if (obs_a() !== e) begin
                $display("FAIL post_reset edge %0d: got %h want %h", k, obs_a(), e);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_latency();
        exp_t e;
        b_reset = 1'b1;
        b_in    = 4'h0;
        repeat (2) tick();
        b_reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            b_in   = (k <= 10) ? 4'hF : 4'h0;
            e.out  = (k >= 8 && k < 18) ? 4'hF : 4'h0;
            e.rise = (k == 8) ? 4'hF : 4'h0;
            e.fall = (k == 18) ? 4'hF : 4'h0;
            e.gl   = 4'h0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_chk++;
            if (obs_b() !== e || b_out_n !== ~e.out) begin
                $display("FAIL latency edge %0d: got %h/n=%h want %h", k, obs_b(), b_out_n, e);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_filt1_random();
        logic [1:0] q[$];
        logic [1:0] x;
        logic [1:0] ex;
        logic [1:0] prev;
        logic [9:0] want;
        c_reset = 1'b1;
        c_in    = 2'b00;
        repeat (2) tick();
        c_reset = 1'b0;
        prev    = 2'b00;
        for (int n = 0; n < 1000; n++) begin
            x    = 2'($urandom_range(0, 3));
            c_in = x;
            q.push_back(x);
            tick();
            if (q.size() == 3) begin
                ex = q.pop_front();
            end else begin
                ex = 2'b00;
            end
            want = {ex, ~ex, ex & ~prev, ~ex & prev, 2'b00};
            prev = ex;
            n_chk++;
            if ({c_out, c_out_n, c_rise, c_fall, c_gl} !== want) begin
                $display("FAIL filt1 cycle %0d: got %b want %b", n,
                         {c_out, c_out_n, c_rise, c_fall, c_gl}, want);
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        a_reset = 1'b1; a_en = 1'b1; a_in = '0; a_clr = '0;
        b_reset = 1'b1; b_en = 1'b1; b_in = '0; b_clr = '0;
        c_reset = 1'b1; c_en = 1'b1; c_in = '0; c_clr = '0;
        test_reset();
        test_glitch();
        test_enable();
        test_set_clear();
        test_latency();
        test_filt1_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
